// File: rtl/branch_redirect.sv
// Branch redirect unit at the odd-pipe tail: squashes younger stages, writes the
// link register and hands a word-aligned redirect PC to fetch over valid/ready.
module branch_redirect #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ibr_branch_flag,
  input  logic [0:31]   ibr_branch_target_addr,
  input  logic [0:31]   ibr_link_addr,
  input  logic          ibr_is_in_delayslot,
  input  logic          ibr_link_wreg,
  input  logic [0:6]    ibr_link_rtaddr,
  input  logic          fetch_ready,
  output logic          flush,
  output logic          redirect_valid,
  output logic [0:31]   redirect_addr,
  output logic          link_wreg,
  output logic [0:6]    link_rtaddr,
  output logic [0:127]  link_rt,
  output logic          busy,
  output logic          align_err,
  output logic          slot_err
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned REG_W  = 7;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned PAD_W  = DATA_W - ADDR_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_d;
  logic               accept_c;
  logic               slot_hit_c;
  logic               misaligned_c;
  logic [0:ADDR_W-1]  aligned_target_c;

  // A flagged branch sitting in a delay slot is never taken, only reported.
  assign slot_hit_c       = ibr_branch_flag & ibr_is_in_delayslot;
  assign misaligned_c     = |ibr_branch_target_addr[30:31];
  assign aligned_target_c = {ibr_branch_target_addr[0:29], 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic; branches seen outside IDLE are squashed younger work.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    accept_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (ibr_branch_flag && !ibr_is_in_delayslot) begin
          accept_c = 1'b1;
          cnt_d    = CNT_W'(FLUSH_CYCLES);
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (fetch_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are registered copies of the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      busy           <= 1'b0;
      link_wreg      <= 1'b0;
      align_err      <= 1'b0;
      slot_err       <= 1'b0;
    end else begin
      flush          <= (state_d == FLUSH);
      redirect_valid <= (state_d == REDIRECT);
      busy           <= (state_d != IDLE);
      link_wreg      <= accept_c & ibr_link_wreg;
      align_err      <= accept_c & misaligned_c;
      if (slot_hit_c) begin
        slot_err <= 1'b1;
      end
    end
  end

  // Captured redirect PC and link write payload, held until the next acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_addr <= '0;
      link_rtaddr   <= '0;
      link_rt       <= '0;
    end else begin
      if (accept_c) begin
        redirect_addr <= aligned_target_c;
      end
      if (accept_c && ibr_link_wreg) begin
        link_rtaddr <= REG_W'(ibr_link_rtaddr);
        link_rt     <= {ibr_link_addr, PAD_W'(0)};
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect.sv
// Randomized bench for branch_redirect against an age-based reference model.
module tb_branch_redirect;

  localparam int FC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ibr_branch_flag;
  logic [0:31]   ibr_branch_target_addr;
  logic [0:31]   ibr_link_addr;
  logic          ibr_is_in_delayslot;
  logic          ibr_link_wreg;
  logic [0:6]    ibr_link_rtaddr;
  logic          fetch_ready;
  logic          flush;
  logic          redirect_valid;
  logic [0:31]   redirect_addr;
  logic          link_wreg;
  logic [0:6]    link_rtaddr;
  logic [0:127]  link_rt;
  logic          busy;
  logic          align_err;
  logic          slot_err;

  always #5 clk = ~clk;

  branch_redirect #(.FLUSH_CYCLES(FC)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .ibr_branch_flag        (ibr_branch_flag),
    .ibr_branch_target_addr (ibr_branch_target_addr),
    .ibr_link_addr          (ibr_link_addr),
    .ibr_is_in_delayslot    (ibr_is_in_delayslot),
    .ibr_link_wreg          (ibr_link_wreg),
    .ibr_link_rtaddr        (ibr_link_rtaddr),
    .fetch_ready            (fetch_ready),
    .flush                  (flush),
    .redirect_valid         (redirect_valid),
    .redirect_addr          (redirect_addr),
    .link_wreg              (link_wreg),
    .link_rtaddr            (link_rtaddr),
    .link_rt                (link_rt),
    .busy                   (busy),
    .align_err              (align_err),
    .slot_err               (slot_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: a pending branch is described by the cycle it was accepted in.
  bit          m_active = 0;
  int          m_acc    = 0;
  bit          m_slot   = 0;
  bit          m_lw     = 0;
  bit          m_align  = 0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_link   = '0;
  logic [6:0]  m_rt     = '0;
  bit          m_addr_fresh = 1;
  bit          m_link_fresh = 1;
  int          m_hs     = 0;
  int          dut_hs   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_update();
    int age;
    bit was_active;
    logic [31:0] tgt;
    tgt = ibr_branch_target_addr;
    if (!rst) begin
      m_active = 0; m_slot = 0; m_lw = 0; m_align = 0;
      m_addr = '0; m_link = '0; m_rt = '0;
      m_addr_fresh = 1; m_link_fresh = 1;
    end else begin
      age        = cyc - m_acc;
      was_active = m_active;
      m_lw       = 0;
      m_align    = 0;
      if (ibr_branch_flag && ibr_is_in_delayslot) m_slot = 1;
      if (m_active && age > FC && fetch_ready) begin
        m_active = 0;
        m_hs++;
      end
      if (!was_active && ibr_branch_flag && !ibr_is_in_delayslot) begin
        m_active     = 1;
        m_acc        = cyc;
        m_addr       = tgt - (tgt % 32'd4);
        m_align      = (tgt % 32'd4) != 0;
        m_addr_fresh = 0;
        if (ibr_link_wreg) begin
          m_lw         = 1;
          m_rt         = ibr_link_rtaddr;
          m_link       = ibr_link_addr;
          m_link_fresh = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    int age;
    bit e_fl, e_rv;
    age  = cyc - m_acc;
    e_fl = m_active && age >= 1 && age <= FC;
    e_rv = m_active && age > FC;
    check_val("flush", flush, e_fl);
    check_val("redirect_valid", redirect_valid, e_rv);
    check_val("busy", busy, m_active);
    check_val("link_wreg", link_wreg, m_lw);
    check_val("align_err", align_err, m_align);
    check_val("slot_err", slot_err, m_slot);
    if (e_rv || m_addr_fresh) check_val("redirect_addr", redirect_addr, m_addr);
    if (m_lw || m_link_fresh) begin
      check_val("link_rtaddr", link_rtaddr, m_rt);
      check_val("link_rt", link_rt, {m_link, 96'h0});
    end
  endtask

  // One cycle: drive at the falling edge, model at the rising edge, check at the next fall.
  task automatic step(input bit r, input bit f, input bit d, input bit lw,
                      input logic [31:0] t, input logic [31:0] l,
                      input logic [6:0] rt, input bit fr);
    rst = r; ibr_branch_flag = f; ibr_is_in_delayslot = d; ibr_link_wreg = lw;
    ibr_branch_target_addr = t; ibr_link_addr = l; ibr_link_rtaddr = rt; fetch_ready = fr;
    if (r && redirect_valid && fr) dut_hs++;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit fr);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 32'h0, 32'h0, 7'h0, fr);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 0; ibr_branch_flag = 0; ibr_is_in_delayslot = 0; ibr_link_wreg = 0;
    ibr_branch_target_addr = '0; ibr_link_addr = '0; ibr_link_rtaddr = '0; fetch_ready = 0;
    @(negedge clk);

    step(0, 0, 0, 0, 32'h0, 32'h0, 7'h0, 0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 7'h0, 0);
    idle(5, 0);

    // Linking branch, fetch ready only once the redirect is up.
    step(1, 1, 0, 1, 32'h0000_1234, 32'h0000_0100, 7'd0, 0);
    idle(FC, 0);
    step(1, 0, 0, 0, 32'h0, 32'h0, 7'h0, 1);
    idle(2, 0);

    // Misaligned target with fetch_ready high throughout.
    step(1, 1, 0, 0, 32'h0000_2003, 32'h0000_0200, 7'd5, 1);
    idle(FC + 3, 1);

    // Backpressure with younger branches injected during FLUSH and REDIRECT.
    step(1, 1, 0, 1, 32'h0000_4000, 32'h0000_0400, 7'd33, 0);
    step(1, 1, 0, 1, 32'h0000_5550, 32'h0000_0555, 7'd44, 0);
    idle(FC - 1, 0);
    for (int i = 0; i < 6; i++) step(1, i[0], 0, 1, 32'h0000_6660, 32'h0000_0666, 7'd55, 0);
    step(1, 1, 0, 1, 32'h0000_7770, 32'h0000_0777, 7'd66, 1);
    idle(3, 0);

    // Delay-slot branch in IDLE: sticky error, no flush.
    step(1, 1, 1, 1, 32'h0000_8880, 32'h0000_0888, 7'd77, 1);
    idle(4, 1);
    step(0, 0, 0, 0, 32'h0, 32'h0, 7'h0, 0);
    idle(2, 1);

    // Reset on the second FLUSH cycle drops the redirect.
    step(1, 1, 0, 1, 32'h0000_9990, 32'h0000_0999, 7'd99, 1);
    idle(1, 1);
    step(0, 0, 0, 0, 32'h0, 32'h0, 7'h0, 1);
    idle(8, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) != 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
           1'($urandom_range(1)), $urandom, $urandom, 7'($urandom_range(127)),
           1'($urandom_range(1)));
    end
    idle(FC + 2, 1);

    check_val("redirect_count", 128'(dut_hs), 128'(m_hs));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect.md
# branch_redirect

Branch redirect unit at the tail of the odd pipe. It consumes the resolved branch record leaving the last forwarding stage (flag, target, link address, delay-slot marker, link destination). It then squashes younger in-flight stages, writes the link value into the register file, and hands a redirect PC to fetch over a valid/ready handshake. It is the sink for the branch fields that the forwarding stages carry forward unchanged.

## Interface
- FLUSH_CYCLES, 3, cycles `flush` is held after a branch is accepted; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (`RST_ENABLE` = 0); sampled only on rising clk.
- ibr_branch_flag  in  1  resolved taken branch in the final forwarding stage this cycle.
- ibr_branch_target_addr  in  [0:31]  branch target byte address.
- ibr_link_addr  in  [0:31]  return address for linking branches.
- ibr_is_in_delayslot  in  1  the branching instruction itself sits in a delay slot.
- ibr_link_wreg  in  1  branch writes its link value to a register.
- ibr_link_rtaddr  in  [0:6]  link destination register.
- fetch_ready  in  1  fetch accepts the redirect this cycle.
- flush  out  1  squash all stages younger than the final forwarding stage.
- redirect_valid  out  1  redirect_addr is valid and pending.
- redirect_addr  out  [0:31]  word-aligned new PC.
- link_wreg  out  1  single-cycle register-file write strobe.
- link_rtaddr  out  [0:6]  write address.
- link_rt  out  [0:127]  write data: bits [0:31] = link address, bits [32:127] = 0 (preferred slot).
- busy  out  1  state != IDLE.
- align_err  out  1  one-cycle pulse when the accepted target had bits [30:31] != 0.
- slot_err  out  1  sticky: a branch flagged in a delay slot was presented; cleared only by reset.

## Operation
- States: IDLE, FLUSH, REDIRECT. Flush counter is 4 bits.
- In IDLE, `ibr_branch_flag=1` with `ibr_is_in_delayslot=0` accepts the branch:
  - capture {target[0:29],2'b00} into the redirect register;
  - load the counter with FLUSH_CYCLES;
  - go to FLUSH;
  - pulse `align_err` if target[30:31] != 0.
- Delay-slot branch (`ibr_branch_flag=1` and `ibr_is_in_delayslot=1`) in any state:
  - not accepted;
  - sets `slot_err`;
  - no flush, no link write.
- FLUSH:
  - `flush=1`;
  - counter decrements each cycle;
  - when it reaches 1 the next state is REDIRECT.
- REDIRECT:
  - `redirect_valid=1` and `redirect_addr` held stable until `fetch_ready=1`;
  - the handshake completes on the edge where both are high;
  - next state IDLE.
- `ibr_branch_flag` seen in FLUSH or REDIRECT is a squashed younger instruction and is ignored. Captured address and counter are unchanged.
- Link write: on acceptance with `ibr_link_wreg=1`, the next cycle drives `link_wreg=1` for exactly one cycle with the captured rtaddr and link data. When `ibr_link_wreg=0`, `link_wreg` stays 0.
- Reset (rst=0 at an edge), including mid-FLUSH or mid-REDIRECT:
  - go to IDLE;
  - pending redirect dropped, no redirect issued afterwards;
  - `slot_err` cleared.

## Timing
- Reset values:
  - `flush`, `redirect_valid`, `link_wreg`, `busy`, `align_err` and `slot_err` = 0;
  - `redirect_addr` = 0;
  - `link_rtaddr` = 0;
  - `link_rt` = 0.
- All outputs are registered.
- Branch sampled at edge N:
  - `flush=1` in cycles N+1 .. N+FLUSH_CYCLES;
  - `redirect_valid=1` from cycle N+FLUSH_CYCLES+1;
  - `link_wreg` and `align_err` are asserted in cycle N+1.
- Minimum branch-to-branch spacing is FLUSH_CYCLES+2 cycles:
  - FLUSH_CYCLES cycles of FLUSH, plus one REDIRECT cycle with `fetch_ready` already high, plus one IDLE cycle;
  - a branch presented in the handshake cycle is ignored.
- `fetch_ready` asserted before REDIRECT has no effect. `fetch_ready` low stalls in REDIRECT indefinitely.
- `busy` = 1 in every FLUSH and REDIRECT cycle.

## Test plan
- Reset, then idle for 5 cycles -> all outputs 0.
- FLUSH_CYCLES=3; branch at N with target 0x0000_1234, link 0x0000_0100, `ibr_link_wreg=1`, rtaddr 7'd0 -> responses:
  - `link_wreg` at N+1 with link_rt[0:31]=0x100, rest 0;
  - `flush` for 3 cycles;
  - `redirect_valid` at N+4 with redirect_addr 0x0000_1234;
  - `fetch_ready=1` at N+4 -> IDLE at N+5.
- Target 0x0000_2003 -> `align_err` pulse at N+1; redirect_addr 0x0000_2000.
- Backpressure: `fetch_ready` low for 6 cycles in REDIRECT -> responses:
  - `redirect_valid` and `redirect_addr` held;
  - a second branch injected during FLUSH and during REDIRECT is ignored;
  - only one redirect completes.
- Delay-slot branch in IDLE -> `slot_err` set and stays set; no flush, no redirect. Reset then clears it.
- Reset asserted on the second FLUSH cycle -> the next cycle shows IDLE with all outputs 0; no redirect follows.
